// File: rtl/macguffin_pkg.sv
// macguffin_pkg
//   Shared constants and default S-box contents for the MacGuffin S-box bank.
//   Each MacGuffin table is the matching DES S-box reduced to its two outer
//   output bits (bit 3 -> result bit 1, bit 0 -> result bit 0). The 6-bit
//   index uses the DES convention: row = {in[5], in[0]}, column = in[4:1].
//   The defaults are built once at elaboration time from the DES tables
//   below, so the 2-bit tables never have to be maintained by hand.
//   Used by macguffin_sbox_bank (plain and MACGUFFIN_SBOX_LOAD_EN builds).
package macguffin_pkg;

  localparam int SBOX_IN_W    = 6;
  localparam int SBOX_OUT_W   = 2;
  localparam int SBOX_NUM_MAX = 8;
  localparam int SBOX_DEPTH   = 64;

  // One table: entry i holds the 2-bit result for input value i.
  typedef logic [SBOX_DEPTH-1:0][SBOX_OUT_W-1:0] sbox_table_t;

  // DES S1..S8, row-major (row*16 + column).
  localparam logic [3:0] DES_SBOX [SBOX_NUM_MAX][SBOX_DEPTH] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
  };

  // Builds MacGuffin table k from DES S-box k.
  function automatic sbox_table_t sbox_default(input int k);
    sbox_table_t t;
    logic [3:0]  d;
    int          row;
    int          col;
    t = '0;
    for (int i = 0; i < SBOX_DEPTH; i++) begin
      row  = ((i >> 4) & 2) | (i & 1);
      col  = (i >> 1) & 15;
      d    = DES_SBOX[k][row*16 + col];
      t[i] = {d[3], d[0]};
    end
    return t;
  endfunction

  localparam sbox_table_t SBOX_DEFAULT [SBOX_NUM_MAX] = '{
    sbox_default(0), sbox_default(1), sbox_default(2), sbox_default(3),
    sbox_default(4), sbox_default(5), sbox_default(6), sbox_default(7)
  };

endpackage

// File: rtl/macguffin_pipe_stage.sv
// macguffin_pipe_stage
//   One valid/ready register slice. The slice accepts a new word whenever it
//   is empty or its current word leaves in the same cycle, giving full
//   throughput with no bubbles. Only the valid flag is reset.
//   Ports:
//     i_clk, i_rst_n         clock, synchronous active-low reset
//     i_valid/o_ready/i_data upstream handshake and data
//     o_valid/i_ready/o_data downstream handshake and data
module macguffin_pipe_stage #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_load;

  assign o_ready = !r_valid || i_ready;
  assign w_load  = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/macguffin_sbox_bank.sv
// macguffin_sbox_bank
//   NUM_SBOX parallel MacGuffin S-box lanes (6-bit in, 2-bit out) behind a
//   valid/ready pipeline of PIPE_STAGES (1 or 2) register slices.
//     PIPE_STAGES=1: in_data -> lookup -> output slice
//     PIPE_STAGES=2: in_data -> input slice -> lookup -> output slice
//   Optional feature macro MACGUFFIN_SBOX_LOAD_EN: tables become writable
//   registers (reloaded with macguffin_pkg::SBOX_DEFAULT on reset) and the
//   cfg_* write port is added. Without it the tables are constants.
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     in_valid/in_ready/in_data  input stream, lane k at in_data[6k+5:6k]
//     out_valid/out_ready/out_data output stream, lane k at out_data[2k+1:2k]
//     cfg_we/cfg_sel/cfg_addr/cfg_data  table write (LOAD_EN build only)
module macguffin_sbox_bank
  import macguffin_pkg::*;
#(
  parameter int NUM_SBOX    = 8,
  parameter int PIPE_STAGES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SBOX_IN_W*NUM_SBOX-1:0]  in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SBOX_OUT_W*NUM_SBOX-1:0] out_data
`ifdef MACGUFFIN_SBOX_LOAD_EN
  ,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_sel,
  input  logic [5:0]                 cfg_addr,
  input  logic [1:0]                 cfg_data
`endif
);

  localparam int IN_W  = SBOX_IN_W * NUM_SBOX;
  localparam int OUT_W = SBOX_OUT_W * NUM_SBOX;

  sbox_table_t        w_table [NUM_SBOX];
  logic               w_cfg_block;
  logic               w_s0_valid_in;
  logic               w_s0_ready;
  logic [IN_W-1:0]    w_lut_in;
  logic [OUT_W-1:0]   w_lut_out;

`ifdef MACGUFFIN_SBOX_LOAD_EN
  sbox_table_t r_table [NUM_SBOX];

  // Writes to a lane that does not exist simply match no k and are dropped.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SBOX; k++) begin
      if (!rst_n) begin
        r_table[k] <= SBOX_DEFAULT[k];
      end else if (cfg_we && (cfg_sel == 3'(k))) begin
        r_table[k][cfg_addr] <= cfg_data;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_SBOX; k++) begin
      w_table[k] = r_table[k];
    end
  end

  // Input is stalled for the whole write cycle.
  assign w_cfg_block = cfg_we;
`else
  always_comb begin
    for (int k = 0; k < NUM_SBOX; k++) begin
      w_table[k] = SBOX_DEFAULT[k];
    end
  end

  assign w_cfg_block = 1'b0;
`endif

  always_comb begin
    w_lut_out = '0;
    for (int k = 0; k < NUM_SBOX; k++) begin
      w_lut_out[SBOX_OUT_W*k +: SBOX_OUT_W] = w_table[k][w_lut_in[SBOX_IN_W*k +: SBOX_IN_W]];
    end
  end

  assign w_s0_valid_in = in_valid && !w_cfg_block;
  assign in_ready      = w_s0_ready && !w_cfg_block;

  generate
    if (PIPE_STAGES == 2) begin : g_two_stage
      logic            w_s0_valid;
      logic            w_s1_ready;
      logic [IN_W-1:0] w_s0_data;

      // Stage 0: register raw input
      macguffin_pipe_stage #(.DATA_W(IN_W)) u_in_stage (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (w_s0_valid_in),
        .o_ready (w_s0_ready),
        .i_data  (in_data),
        .o_valid (w_s0_valid),
        .i_ready (w_s1_ready),
        .o_data  (w_s0_data)
      );

      assign w_lut_in = w_s0_data;

      // Stage 1: register lookup result
      macguffin_pipe_stage #(.DATA_W(OUT_W)) u_out_stage (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (w_s0_valid),
        .o_ready (w_s1_ready),
        .i_data  (w_lut_out),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (out_data)
      );
    end else begin : g_one_stage
      assign w_lut_in = in_data;

      // Stage 0: lookup straight from in_data into the output register
      macguffin_pipe_stage #(.DATA_W(OUT_W)) u_out_stage (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (w_s0_valid_in),
        .o_ready (w_s0_ready),
        .i_data  (w_lut_out),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (out_data)
      );
    end
  endgenerate

endmodule

// File: tb/tb_macguffin_sbox_bank.sv
// tb_macguffin_sbox_bank
//   Drives two instances of macguffin_sbox_bank (PIPE_STAGES=1 and 2) with
//   directed vectors and a random stream; honours MACGUFFIN_SBOX_LOAD_EN.
module tb_macguffin_sbox_bank;
  import macguffin_pkg::*;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid  [2];
  logic           in_ready  [2];
  logic [6*N-1:0] in_data   [2];
  logic           out_valid [2];
  logic           out_ready [2];
  logic [2*N-1:0] out_data  [2];
`ifdef MACGUFFIN_SBOX_LOAD_EN
  logic           cfg_we;
  logic [2:0]     cfg_sel;
  logic [5:0]     cfg_addr;
  logic [1:0]     cfg_data;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  macguffin_sbox_bank #(.NUM_SBOX(N), .PIPE_STAGES(1)) u_p1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0])
`ifdef MACGUFFIN_SBOX_LOAD_EN
    , .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
`endif
  );

  macguffin_sbox_bank #(.NUM_SBOX(N), .PIPE_STAGES(2)) u_p2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1])
`ifdef MACGUFFIN_SBOX_LOAD_EN
    , .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6*N-1:0] lane1(input int v);
    logic [6*N-1:0] w;
    w = '0;
    w[11:6] = 6'(v);
    return w;
  endfunction

  function automatic logic [2*N-1:0] model(input logic [6*N-1:0] x);
    logic [2*N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[2*k +: 2] = SBOX_DEFAULT[k][x[6*k +: 6]];
    return r;
  endfunction

  // Lanes 0..7 inputs 6,4,0,4,1,33,2,63 -> outputs 1,2,2,2,2,0,3,3
  localparam logic [6*N-1:0] MULTI_IN  = {6'd63, 6'd2, 6'd33, 6'd1, 6'd4, 6'd0, 6'd4, 6'd6};
  localparam logic [2*N-1:0] MULTI_OUT = 16'hF2A9;

  int             v_b2b [4] = '{0, 1, 4, 63};
  int             e_b2b [4] = '{3, 1, 2, 3};
  int             v_bp  [4] = '{0, 1, 4, 5};
  int             e_bp  [4] = '{3, 1, 2, 0};
  int             acc, got, p;
  logic           take, have;
  logic [2*N-1:0] held, expv;
  logic [2*N-1:0] q0 [$];
  logic [2*N-1:0] q1 [$];
  int             acc_n [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b1;
    end
`ifdef MACGUFFIN_SBOX_LOAD_EN
    cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
`endif
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_out_valid_p%0d", d+1), 64'(out_valid[d]), 64'(0));
      chk($sformatf("reset_in_ready_p%0d", d+1), 64'(in_ready[d]), 64'(1));
    end

    // back-to-back lane 1 on the one-stage instance
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = lane1(v_b2b[i]);
      #1;
      chk("b2b_in_ready", 64'(in_ready[0]), 64'(1));
      tick();
      chk("b2b_out_valid", 64'(out_valid[0]), 64'(1));
      chk($sformatf("b2b_lane1_in%0d", v_b2b[i]), 64'(out_data[0][3:2]), 64'(e_b2b[i]));
    end
    in_valid[0] = 1'b0;
    tick();
    chk("b2b_drained", 64'(out_valid[0]), 64'(0));

    in_valid[0] = 1'b1; in_data[0] = MULTI_IN;
    tick();
    in_valid[0] = 1'b0;
    chk("multi_lane_p1", 64'(out_data[0]), 64'(MULTI_OUT));
    tick();

    // two-stage latency
    in_valid[1] = 1'b1; in_data[1] = lane1(6);
    tick();
    in_valid[1] = 1'b0;
    chk("p2_lat_cycle1", 64'(out_valid[1]), 64'(0));
    tick();
    chk("p2_lat_cycle2", 64'(out_valid[1]), 64'(1));
    chk("p2_lane1_in6", 64'(out_data[1][3:2]), 64'(2));
    tick();
    chk("p2_consumed", 64'(out_valid[1]), 64'(0));
    in_valid[1] = 1'b1; in_data[1] = MULTI_IN;
    tick();
    in_valid[1] = 1'b0;
    tick();
    chk("multi_lane_p2", 64'(out_data[1]), 64'(MULTI_OUT));
    tick();

    // backpressure then release, per instance
    for (int d = 0; d < 2; d++) begin
      p = d + 1;
      out_ready[d] = 1'b0;
      acc = 0; have = 1'b0; held = '0;
      for (int c = 0; c < 5; c++) begin
        in_valid[d] = (acc < 4);
        if (acc < 4) in_data[d] = lane1(v_bp[acc]);
        #1;
        take = in_valid[d] && in_ready[d];
        tick();
        if (take) acc++;
        if (out_valid[d]) begin
          if (!have) begin
            held = out_data[d];
            have = 1'b1;
            chk($sformatf("bp_head_p%0d", p), 64'(out_data[d][3:2]), 64'(e_bp[0]));
          end else begin
            chk($sformatf("bp_stable_p%0d", p), 64'(out_data[d]), 64'(held));
          end
        end
      end
      chk($sformatf("bp_accept_bound_p%0d", p), 64'((acc >= p) && (acc <= p + 1)), 64'(1));
      out_ready[d] = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
        in_valid[d] = (acc < 4);
        if (acc < 4) in_data[d] = lane1(v_bp[acc]);
        #1;
        take = in_valid[d] && in_ready[d];
        if (out_valid[d] && out_ready[d]) begin
          chk($sformatf("bp_order_p%0d_w%0d", p, got), 64'(out_data[d][3:2]), 64'(e_bp[got]));
          got++;
        end
        tick();
        if (take) acc++;
      end
      in_valid[d] = 1'b0;
      chk($sformatf("bp_all_released_p%0d", p), 64'(got), 64'(4));
      tick();
      chk($sformatf("bp_empty_p%0d", p), 64'(out_valid[d]), 64'(0));
    end

    // reset with words in flight
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = 1'b0; in_valid[d] = 1'b1; in_data[d] = lane1(0);
    end
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      chk($sformatf("pre_reset_valid_p%0d", d+1), 64'(out_valid[d]), 64'(1));
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("flush_out_valid_p%0d", d+1), 64'(out_valid[d]), 64'(0));
      chk($sformatf("flush_in_ready_p%0d", d+1), 64'(in_ready[d]), 64'(1));
      out_ready[d] = 1'b1;
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int d = 0; d < 2; d++)
        chk($sformatf("flush_no_emit_p%0d", d+1), 64'(out_valid[d]), 64'(0));
    end

`ifdef MACGUFFIN_SBOX_LOAD_EN
    // table write: two-stage instance has a word in stage 0 during the write
    in_valid[1] = 1'b1; in_data[1] = lane1(0);
    tick();
    in_valid[1] = 1'b0;
    cfg_we = 1'b1; cfg_sel = 3'd1; cfg_addr = 6'd0; cfg_data = 2'd0;
    in_valid[0] = 1'b1; in_data[0] = lane1(0);
    #1;
    chk("cfg_in_ready_p1", 64'(in_ready[0]), 64'(0));
    chk("cfg_in_ready_p2", 64'(in_ready[1]), 64'(0));
    tick();
    cfg_we = 1'b0;
    chk("cfg_no_accept_p1", 64'(out_valid[0]), 64'(0));
    chk("cfg_old_value_p2", 64'(out_data[1][3:2]), 64'(3));
    tick();
    in_valid[0] = 1'b0;
    chk("cfg_new_valid_p1", 64'(out_valid[0]), 64'(1));
    chk("cfg_new_value_p1", 64'(out_data[0][3:2]), 64'(0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid[0] = 1'b1; in_data[0] = lane1(0);
    tick();
    in_valid[0] = 1'b0;
    chk("cfg_reload_default", 64'(out_data[0][3:2]), 64'(3));
    tick();
`endif

    // random stream with random backpressure on both instances
    acc_n[0] = 0; acc_n[1] = 0;
    for (int c = 0; c < 40000 &&
         (acc_n[0] < 10000 || acc_n[1] < 10000 || q0.size() > 0 || q1.size() > 0); c++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = (acc_n[d] < 10000) && ($urandom_range(0, 3) != 0);
        in_data[d]   = {16'($urandom()), $urandom()};
        out_ready[d] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        if (out_valid[d] && out_ready[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("rnd_spurious_p%0d", d+1), 64'(1), 64'(0));
          end else begin
            if (d == 0) expv = q0.pop_front();
            else        expv = q1.pop_front();
            chk($sformatf("rnd_data_p%0d", d+1), 64'(out_data[d]), 64'(expv));
          end
        end
        if (in_valid[d] && in_ready[d]) begin
          if (d == 0) q0.push_back(model(in_data[d]));
          else        q1.push_back(model(in_data[d]));
          acc_n[d]++;
        end
      end
      tick();
    end
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
    chk("rnd_accepted_p1", 64'(acc_n[0]), 64'(10000));
    chk("rnd_accepted_p2", 64'(acc_n[1]), 64'(10000));
    chk("rnd_drained_p1", 64'(q0.size()), 64'(0));
    chk("rnd_drained_p2", 64'(q1.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
